// File: rtl/gr_apb_reg_slave.sv
// rtl/gr_apb_reg_slave.sv - APB completer with a decoded window of 32-bit RW/RO registers
//
// Purpose:
//   Terminates an APB bus and decodes a word-aligned window of NUM_REGS 32-bit
//   registers starting at BASE_ADDR. Each transfer is stretched by WAIT_STATES
//   access cycles before pready. RW registers are exported on o_reg_out with a
//   one-cycle o_wr_pulse per committed write; RO registers read i_hw_status.
//   Every output is registered.
//
// Ports:
//   i_clk        clock, all logic on posedge
//   i_reset      synchronous active-low reset
//   i_paddr      APB address (ADDR_W)
//   i_psel       APB select
//   i_penable    APB enable (access phase)
//   i_pwrite     1 = write, 0 = read
//   i_pwdata     write data
//   o_prdata     read data, nonzero only while o_pready = 1
//   o_pready     transfer complete
//   o_pslverr    transfer error, only while o_pready = 1
//   i_hw_status  RO register sources, slice i = register i
//   o_reg_out    RW register contents, RO slices read as 0
//   o_wr_pulse   one-cycle strobe in the cycle after a committed write

module gr_apb_reg_slave #(
  parameter int unsigned           ADDR_W      = 64,
  parameter int unsigned           NUM_REGS    = 16,
  parameter logic [ADDR_W-1:0]     BASE_ADDR   = '0,
  parameter int unsigned           WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0]   RO_MASK     = '0
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [ADDR_W-1:0]        i_paddr,
  input  logic                     i_psel,
  input  logic                     i_penable,
  input  logic                     i_pwrite,
  input  logic [31:0]              i_pwdata,
  output logic [31:0]              o_prdata,
  output logic                     o_pready,
  output logic                     o_pslverr,
  input  logic [32*NUM_REGS-1:0]   i_hw_status,
  output logic [32*NUM_REGS-1:0]   o_reg_out,
  output logic [NUM_REGS-1:0]      o_wr_pulse
);

  localparam logic [ADDR_W-1:0] LP_SPAN = ADDR_W'(4 * NUM_REGS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS} state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [3:0]              r_cnt;
  logic [4:0]              r_idx;
  logic                    r_err;
  logic                    r_write;
  logic [31:0]             r_prdata;
  logic                    r_pready;
  logic                    r_pslverr;
  logic [32*NUM_REGS-1:0]  r_reg_out;
  logic [NUM_REGS-1:0]     r_wr_pulse;

  logic                    w_setup;
  logic [ADDR_W-1:0]       w_off;
  logic [4:0]              w_idx;
  logic                    w_is_ro;
  logic                    w_err;
  logic [4:0]              w_sel_idx;
  logic                    w_sel_err;
  logic                    w_sel_write;
  logic [31:0]             w_rd_data;
  logic                    w_enter_access;
  logic                    w_commit;

  assign w_setup = i_psel & ~i_penable;
  assign w_off   = i_paddr - BASE_ADDR;
  assign w_idx   = w_off[6:2];

  always_comb begin
    w_is_ro = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_idx == 5'(i)) w_is_ro = RO_MASK[i];
    end
  end

  // An address below the base wraps w_off to a huge value, so the span
  // compare alone would catch it; the explicit test keeps intent readable.
  assign w_err = (i_paddr[1:0] != 2'b00) || (i_paddr < BASE_ADDR) ||
                 (w_off >= LP_SPAN) || (i_pwrite && w_is_ro);

  // With zero wait states ACCESS is entered on the setup edge itself, before
  // the latched decode exists, so the live decode is used from IDLE.
  assign w_sel_idx   = (r_state == S_IDLE) ? w_idx    : r_idx;
  assign w_sel_err   = (r_state == S_IDLE) ? w_err    : r_err;
  assign w_sel_write = (r_state == S_IDLE) ? i_pwrite : r_write;

  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_sel_idx == 5'(i)) begin
        w_rd_data = RO_MASK[i] ? i_hw_status[32*i +: 32] : r_reg_out[32*i +: 32];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_setup) w_next = (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
      end
      S_WAIT: begin
        if (!i_psel)                            w_next = S_IDLE;
        else if (i_penable && (r_cnt == 4'd1))  w_next = S_ACCESS;
      end
      S_ACCESS: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  assign w_enter_access = (w_next == S_ACCESS) && (r_state != S_ACCESS);
  // Completion is the ACCESS edge with psel still high; psel low there is an abort.
  assign w_commit = (r_state == S_ACCESS) && i_psel && r_write && !r_err;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_cnt      <= '0;
      r_idx      <= '0;
      r_err      <= 1'b0;
      r_write    <= 1'b0;
      r_prdata   <= '0;
      r_pready   <= 1'b0;
      r_pslverr  <= 1'b0;
      r_reg_out  <= '0;
      r_wr_pulse <= '0;
    end else begin
      r_wr_pulse <= '0;

      if ((r_state == S_IDLE) && w_setup) begin
        r_idx   <= w_idx;
        r_err   <= w_err;
        r_write <= i_pwrite;
        r_cnt   <= 4'(WAIT_STATES);
      end else if (r_state == S_WAIT) begin
        if (!i_psel)        r_cnt <= '0;
        else if (i_penable) r_cnt <= r_cnt - 4'd1;
      end

      if (w_commit) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (r_idx == 5'(i)) begin
            r_reg_out[32*i +: 32] <= i_pwdata;
            r_wr_pulse[i]         <= 1'b1;
          end
        end
      end

      if (w_enter_access) begin
        r_pready  <= 1'b1;
        r_pslverr <= w_sel_err;
        r_prdata  <= (w_sel_err || w_sel_write) ? 32'h0 : w_rd_data;
      end else begin
        r_pready  <= 1'b0;
        r_pslverr <= 1'b0;
        r_prdata  <= '0;
      end
    end
  end

  assign o_prdata   = r_prdata;
  assign o_pready   = r_pready;
  assign o_pslverr  = r_pslverr;
  assign o_reg_out  = r_reg_out;
  assign o_wr_pulse = r_wr_pulse;

endmodule

// File: tb/tb_gr_apb_reg_slave.sv
// tb/tb_gr_apb_reg_slave.sv - testbench for gr_apb_reg_slave over three configurations

module tb_gr_apb_reg_slave;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [63:0] paddr = '0;
  logic [2:0]  psel = '0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [31:0] pwdata = '0;
  logic [255:0] hs0;
  logic [511:0] hs1;
  logic [127:0] hs2;

  wire [95:0]  prdata_v;
  wire [2:0]   pready_v;
  wire [2:0]   pslverr_v;
  wire [255:0] ro0;
  wire [511:0] ro1;
  wire [127:0] ro2;
  wire [7:0]   wp0;
  wire [15:0]  wp1;
  wire [3:0]   wp2;

  always #5 clk = ~clk;

  gr_apb_reg_slave #(.ADDR_W(32), .NUM_REGS(8), .BASE_ADDR(32'h100), .WAIT_STATES(0), .RO_MASK(8'h02)) dut0 (
    .i_clk(clk), .i_reset(reset), .i_paddr(paddr[31:0]), .i_psel(psel[0]), .i_penable(penable),
    .i_pwrite(pwrite), .i_pwdata(pwdata), .o_prdata(prdata_v[31:0]), .o_pready(pready_v[0]),
    .o_pslverr(pslverr_v[0]), .i_hw_status(hs0), .o_reg_out(ro0), .o_wr_pulse(wp0));

  gr_apb_reg_slave #(.WAIT_STATES(3)) dut1 (
    .i_clk(clk), .i_reset(reset), .i_paddr(paddr), .i_psel(psel[1]), .i_penable(penable),
    .i_pwrite(pwrite), .i_pwdata(pwdata), .o_prdata(prdata_v[63:32]), .o_pready(pready_v[1]),
    .o_pslverr(pslverr_v[1]), .i_hw_status(hs1), .o_reg_out(ro1), .o_wr_pulse(wp1));

  gr_apb_reg_slave #(.ADDR_W(32), .NUM_REGS(4), .BASE_ADDR(32'h40), .WAIT_STATES(4), .RO_MASK(4'h8)) dut2 (
    .i_clk(clk), .i_reset(reset), .i_paddr(paddr[31:0]), .i_psel(psel[2]), .i_penable(penable),
    .i_pwrite(pwrite), .i_pwdata(pwdata), .o_prdata(prdata_v[95:64]), .o_pready(pready_v[2]),
    .o_pslverr(pslverr_v[2]), .i_hw_status(hs2), .o_reg_out(ro2), .o_wr_pulse(wp2));

  int          nregs [3] = '{8, 16, 4};
  logic [63:0] bases [3] = '{64'h100, 64'h0, 64'h40};
  int          waits [3] = '{0, 3, 4};
  logic [31:0] romask[3] = '{32'h02, 32'h0, 32'h08};
  logic [31:0] mregs [3][16];

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int          d;
    logic [63:0] addr;
    bit          wr;
    logic [31:0] wd;
    bit          eerr;
    logic [31:0] erd;
    int          gap;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int d, logic [63:0] a, bit wr, logic [31:0] wd, bit ee, logic [31:0] er, int gap);
    vec_t v;
    v.d = d; v.addr = a; v.wr = wr; v.wd = wd; v.eerr = ee; v.erd = er; v.gap = gap;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] hw_slice(int d, int i);
    case (d)
      0:       return hs0[32*i +: 32];
      1:       return hs1[32*i +: 32];
      default: return hs2[32*i +: 32];
    endcase
  endfunction

  function automatic logic [511:0] act_regout(int d);
    case (d)
      0:       return {256'h0, ro0};
      1:       return ro1;
      default: return {384'h0, ro2};
    endcase
  endfunction

  function automatic logic [31:0] act_wp(int d);
    case (d)
      0:       return 32'(wp0);
      1:       return 32'(wp1);
      default: return 32'(wp2);
    endcase
  endfunction

  function automatic logic [511:0] exp_regout(int d);
    logic [511:0] v = '0;
    for (int i = 0; i < nregs[d]; i++)
      if (!romask[d][i]) v[32*i +: 32] = mregs[d][i];
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < 16; i++) mregs[d][i] = '0;
  endtask

  task automatic check_all_zero(input string tag);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("%s d%0d pready", tag, d), pready_v[d], 0);
      chk($sformatf("%s d%0d pslverr", tag, d), pslverr_v[d], 0);
      chk($sformatf("%s d%0d prdata", tag, d), prdata_v[32*d +: 32], 0);
      chk($sformatf("%s d%0d wr_pulse", tag, d), act_wp(d), 0);
      chk($sformatf("%s d%0d reg_out", tag, d), act_regout(d), 0);
    end
  endtask

  // One complete transfer starting in its setup cycle; returns in the cycle after
  // completion with psel low, so a following call is back-to-back.
  task automatic xfer(input int d, input logic [63:0] addr, input bit wr, input logic [31:0] wd,
                      output bit o_err, output logic [31:0] o_rd);
    bit          in_win, ro, eerr;
    int          idx, lat;
    logic [31:0] erd;
    in_win = (addr >= bases[d]) && (addr < bases[d] + 64'(4 * nregs[d]));
    idx    = in_win ? int'((addr - bases[d]) / 4) : 0;
    ro     = in_win && romask[d][idx];
    eerr   = (addr % 4 != 0) || !in_win || (wr && ro);
    erd    = eerr ? 32'h0 : (ro ? hw_slice(d, idx) : mregs[d][idx]);

    psel = '0; psel[d] = 1'b1; penable = 1'b0;
    paddr = addr; pwrite = wr; pwdata = wd;
    tick();
    penable = 1'b1;
    chk($sformatf("d%0d wr_pulse_clear", d), act_wp(d), 0);
    lat = 0;
    while (!pready_v[d] && lat < 40) begin
      chk($sformatf("d%0d wait_prdata", d), prdata_v[32*d +: 32], 0);
      chk($sformatf("d%0d wait_pslverr", d), pslverr_v[d], 0);
      tick();
      lat++;
    end
    chk($sformatf("d%0d latency a=%0h", d, addr), lat, waits[d]);
    o_err = pslverr_v[d];
    o_rd  = prdata_v[32*d +: 32];
    chk($sformatf("d%0d pslverr a=%0h", d, addr), o_err, eerr);
    if (!wr) chk($sformatf("d%0d prdata a=%0h", d, addr), o_rd, erd);
    if (!eerr && wr) mregs[d][idx] = wd;
    tick();
    psel = '0; penable = 1'b0;
    chk($sformatf("d%0d pready_drop", d), pready_v[d], 0);
    chk($sformatf("d%0d wr_pulse a=%0h", d, addr), act_wp(d), (!eerr && wr) ? (32'h1 << idx) : 32'h0);
    chk($sformatf("d%0d reg_out", d), act_regout(d), exp_regout(d));
  endtask

  initial begin
    bit          e;
    logic [31:0] rd;
    clear_model();
    for (int i = 0; i < 8; i++)  hs0[32*i +: 32] = $urandom;
    for (int i = 0; i < 16; i++) hs1[32*i +: 32] = $urandom;
    for (int i = 0; i < 4; i++)  hs2[32*i +: 32] = $urandom;
    hs0[63:32]  = 32'h1234;
    hs2[127:96] = 32'hCAFE0003;

    repeat (3) tick();
    check_all_zero("reset");
    reset = 1'b1;
    tick();

    tbl.push_back(mk(0, 64'h108, 1, 32'hDEADBEEF, 0, 32'h0,        1));
    tbl.push_back(mk(0, 64'h108, 0, 32'h0,        0, 32'hDEADBEEF, 0));
    tbl.push_back(mk(1, 64'h000, 1, 32'hA5A50001, 0, 32'h0,        0));
    tbl.push_back(mk(1, 64'h000, 0, 32'h0,        0, 32'hA5A50001, 1));
    tbl.push_back(mk(0, 64'h120, 1, 32'h12345678, 1, 32'h0,        0));
    tbl.push_back(mk(0, 64'h102, 1, 32'h12345678, 1, 32'h0,        0));
    tbl.push_back(mk(0, 64'h0FC, 0, 32'h0,        1, 32'h0,        0));
    tbl.push_back(mk(0, 64'h104, 0, 32'h0,        0, 32'h1234,     0));
    tbl.push_back(mk(0, 64'h104, 1, 32'hFFFF,     1, 32'h0,        0));
    tbl.push_back(mk(0, 64'h104, 0, 32'h0,        0, 32'h1234,     0));
    tbl.push_back(mk(1, 64'h000, 1, 32'h11111111, 0, 32'h0,        2));
    tbl.push_back(mk(1, 64'h004, 1, 32'h22222222, 0, 32'h0,        0));
    tbl.push_back(mk(1, 64'h008, 1, 32'h33333333, 0, 32'h0,        0));
    tbl.push_back(mk(1, 64'h004, 0, 32'h0,        0, 32'h22222222, 0));
    tbl.push_back(mk(1, 64'h040, 0, 32'h0,        1, 32'h0,        0));
    tbl.push_back(mk(1, 64'h03C, 0, 32'h0,        0, 32'h0,        0));
    tbl.push_back(mk(0, 64'h11C, 1, 32'hC0DE0007, 0, 32'h0,        0));
    tbl.push_back(mk(0, 64'h11C, 0, 32'h0,        0, 32'hC0DE0007, 0));
    tbl.push_back(mk(2, 64'h04C, 0, 32'h0,        0, 32'hCAFE0003, 1));
    tbl.push_back(mk(2, 64'h04C, 1, 32'h1,        1, 32'h0,        0));
    tbl.push_back(mk(2, 64'h050, 0, 32'h0,        1, 32'h0,        0));
    tbl.push_back(mk(2, 64'h048, 1, 32'h0000ABCD, 0, 32'h0,        0));
    tbl.push_back(mk(0, 64'h100, 1, 32'hAAAA0000, 0, 32'h0,        2));
    tbl.push_back(mk(0, 64'h108, 1, 32'hAAAA0002, 0, 32'h0,        0));
    tbl.push_back(mk(0, 64'h10C, 1, 32'hAAAA0003, 0, 32'h0,        0));
    tbl.push_back(mk(0, 64'h100, 0, 32'h0,        0, 32'hAAAA0000, 0));

    foreach (tbl[k]) begin
      repeat (tbl[k].gap) tick();
      xfer(tbl[k].d, tbl[k].addr, tbl[k].wr, tbl[k].wd, e, rd);
      chk($sformatf("row%0d err", k), e, tbl[k].eerr);
      if (!tbl[k].wr) chk($sformatf("row%0d rdata", k), rd, tbl[k].erd);
    end

    // Abort during WAIT on the four-wait-state instance.
    tick();
    psel = 3'b100; penable = 1'b0; paddr = 64'h40; pwrite = 1'b1; pwdata = 32'h5555AAAA;
    tick();
    penable = 1'b1;
    repeat (2) begin
      tick();
      chk("abort_wait pready", pready_v[2], 0);
    end
    psel = '0; penable = 1'b0;
    tick();
    chk("abort_wait pready_after", pready_v[2], 0);
    chk("abort_wait pslverr_after", pslverr_v[2], 0);
    tick();
    chk("abort_wait wr_pulse", act_wp(2), 0);
    chk("abort_wait reg_out", act_regout(2), exp_regout(2));
    repeat (5) begin
      tick();
      chk("abort_wait stays_idle", pready_v[2], 0);
    end
    xfer(2, 64'h40, 0, 32'h0, e, rd);

    // Abort in ACCESS on the zero-wait-state instance.
    psel = 3'b001; penable = 1'b0; paddr = 64'h10C; pwrite = 1'b1; pwdata = 32'h77777777;
    tick();
    chk("abort_access pready_up", pready_v[0], 1);
    psel = '0; penable = 1'b0;
    tick();
    chk("abort_access pready", pready_v[0], 0);
    chk("abort_access wr_pulse", act_wp(0), 0);
    chk("abort_access reg_out", act_regout(0), exp_regout(0));
    xfer(0, 64'h10C, 0, 32'h0, e, rd);
    chk("abort_access readback", rd, 32'hAAAA0003);

    // Reset in the middle of a write.
    psel = 3'b010; penable = 1'b0; paddr = 64'h14; pwrite = 1'b1; pwdata = 32'h99999999;
    tick();
    penable = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check_all_zero("midreset");
    reset = 1'b1; psel = '0; penable = 1'b0;
    clear_model();
    tick();
    check_all_zero("postreset");
    xfer(1, 64'h14, 1, 32'h0BADF00D, e, rd);
    xfer(1, 64'h14, 0, 32'h0, e, rd);
    chk("postreset readback", rd, 32'h0BADF00D);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 200; n++) begin
      int          d, span;
      logic [63:0] lo, a;
      bit          wr;
      d    = $urandom_range(0, 2);
      span = 4 * nregs[d];
      lo   = (bases[d] >= 8) ? bases[d] - 8 : 64'h0;
      a    = lo + 64'($urandom_range(0, span + 16)) & ~64'h3;
      if ($urandom_range(0, 4) == 0) a = a + 64'($urandom_range(1, 3));
      wr   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) begin
        case (d)
          0:       hs0[32*$urandom_range(0, 7) +: 32]  = $urandom;
          1:       hs1[32*$urandom_range(0, 15) +: 32] = $urandom;
          default: hs2[32*$urandom_range(0, 3) +: 32]  = $urandom;
        endcase
      end
      repeat ($urandom_range(0, 2)) tick();
      xfer(d, a, wr, $urandom, e, rd);
    end

    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
